axi4_slave_mem: RTL and testbench
=================================

AXI4_SLAVE_MEM -- requirements
Module: axi4_slave_mem

Interface
REQ-001 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data width in bits; only 32 is supported.
REQ-003 SHALL have parameter MEM_DEPTH, default 1024, number of data words; power of two.
REQ-004 SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1: single clock; all logic on rising edge.
- rst, in, 1: asynchronous, active-high reset.
- s_axi_awvalid / s_axi_awready, in / out, 1 each: write-address handshake.
- s_axi_awaddr, in, ADDR_WIDTH: burst start byte address.
- s_axi_awlen, in, 8: write beats minus 1.
- s_axi_wvalid / s_axi_wready, in / out, 1 each: write-data handshake.
- s_axi_wdata, in, DATA_WIDTH: write data.
- s_axi_wstrb, in, DATA_WIDTH/8: byte enables.
- s_axi_wlast, in, 1: master's last-beat marker.
- s_axi_bvalid / s_axi_bready, out / in, 1 each: write-response handshake.
- s_axi_arvalid / s_axi_arready, in / out, 1 each: read-address handshake.
- s_axi_araddr, in, ADDR_WIDTH: read burst start byte address.
- s_axi_arlen, in, 8: read beats minus 1.
- s_axi_rvalid / s_axi_rready, out / in, 1 each: read-data handshake.
- s_axi_rdata, out, DATA_WIDTH: read data.
- s_axi_rlast, out, 1: last read beat.
- err_wlast, out, 1: sticky flag; wlast disagreed with awlen.

Function
REQ-005 SHALL support INCR bursts only; word index = addr[2 +: log2(MEM_DEPTH)]; addr[1:0] ignored; each beat increments the index by 1, wrapping modulo MEM_DEPTH.
REQ-006 Handshake SHALL occur on a cycle with valid && ready both high; outputs held stable while valid && !ready.
REQ-007 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; awready = 1 only in W_IDLE; wready = 1 only in W_DATA; bvalid = 1 only in W_RESP.
REQ-008 W_IDLE -> W_DATA on AW handshake; SHALL latch start index and awlen; beat counter cleared.
REQ-009 In W_DATA, each W handshake SHALL write byte i of wdata to memory iff wstrb[i], then increment index and counter.
REQ-010 W_DATA -> W_RESP on the handshake where counter == awlen; bvalid SHALL rise the following cycle.
REQ-011 Burst end SHALL be set by awlen only; err_wlast SHALL set if wlast differs from (counter == awlen) on any W beat, and stay set until reset.
REQ-012 W_RESP -> W_IDLE on B handshake; awready SHALL be high the next cycle.
REQ-013 Read FSM SHALL have states R_IDLE, R_DATA; arready = 1 only in R_IDLE; rvalid = 1 only in R_DATA.
REQ-014 On AR handshake, R_IDLE -> R_DATA; rdata SHALL be registered from memory[start index]; rvalid SHALL be 1 the next cycle (latency 1).
REQ-015 In R_DATA, each R handshake before the last SHALL load rdata with the next word in the same edge, giving one beat per cycle under continuous rready.
REQ-016 rlast SHALL be 1 exactly when rvalid and beat counter == arlen; handshake on that beat -> R_IDLE.
REQ-017 Read and write channels SHALL operate independently and concurrently.
REQ-018 If a write beat and a read-data load hit the same word in the same cycle, rdata SHALL return the pre-write value.
REQ-019 awlen = 0 / arlen = 0 SHALL produce single-beat bursts; rlast SHALL be set with the first rvalid.

Reset
REQ-020 rst SHALL asynchronously force both FSMs idle and clear counters and err_wlast. awready and arready SHALL be 1. wready, bvalid, rvalid, rlast and rdata SHALL be 0.
REQ-021 Reset mid-burst SHALL abandon the burst with no further beats or response. Memory contents SHALL NOT be cleared; words already written remain.

Verification
REQ-022 Bench SHALL cover these scenarios:
- AW addr 0x10, len 3; W 0xA0..0xA3 with strb 0xF and wlast on beat 3 -> bvalid the cycle after beat 3; words 4..7 = 0xA0..0xA3; err_wlast = 0.
- AR addr 0x10, len 3, rready held 1 -> rvalid one cycle after AR; rdata 0xA0..0xA3 on consecutive cycles; rlast only with 0xA3.
- Word 4 = 0x11223344; write 0xFFFFFFFF with strb 0x5 -> read gives 0x11FF33FF.
- AW addr (MEM_DEPTH-1)*4, len 1 -> second beat lands in word 0; read back matches.
- wlast asserted on beat 1 of a len-3 burst -> err_wlast = 1; 4 beats still accepted; bvalid follows beat 3.
- rready toggled 1,0,0,1 mid-burst -> rdata/rlast stable during stalls.
- rst pulsed mid-read -> rvalid = 0 immediately (asynchronous); arready = 1 after release; memory unchanged.

Source files
------------

// File: rtl/axi4_slave_mem_if.sv
// AXI4 slave-memory bus: write address/data/response and read address/data channels.
// Sideband status (err_wlast), clock and reset stay outside the bundle.
interface axi4_slave_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    s_axi_awvalid;
  logic                    s_axi_awready;
  logic [ADDR_WIDTH-1:0]   s_axi_awaddr;
  logic [7:0]              s_axi_awlen;

  logic                    s_axi_wvalid;
  logic                    s_axi_wready;
  logic [DATA_WIDTH-1:0]   s_axi_wdata;
  logic [DATA_WIDTH/8-1:0] s_axi_wstrb;
  logic                    s_axi_wlast;

  logic                    s_axi_bvalid;
  logic                    s_axi_bready;

  logic                    s_axi_arvalid;
  logic                    s_axi_arready;
  logic [ADDR_WIDTH-1:0]   s_axi_araddr;
  logic [7:0]              s_axi_arlen;

  logic                    s_axi_rvalid;
  logic                    s_axi_rready;
  logic [DATA_WIDTH-1:0]   s_axi_rdata;
  logic                    s_axi_rlast;

  modport slave (
    input  s_axi_awvalid, s_axi_awaddr, s_axi_awlen,
    output s_axi_awready,
    input  s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast,
    output s_axi_wready,
    output s_axi_bvalid,
    input  s_axi_bready,
    input  s_axi_arvalid, s_axi_araddr, s_axi_arlen,
    output s_axi_arready,
    output s_axi_rvalid, s_axi_rdata, s_axi_rlast,
    input  s_axi_rready
  );

  modport master (
    output s_axi_awvalid, s_axi_awaddr, s_axi_awlen,
    input  s_axi_awready,
    output s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast,
    input  s_axi_wready,
    input  s_axi_bvalid,
    output s_axi_bready,
    output s_axi_arvalid, s_axi_araddr, s_axi_arlen,
    input  s_axi_arready,
    input  s_axi_rvalid, s_axi_rdata, s_axi_rlast,
    output s_axi_rready
  );
endinterface

// File: rtl/axi4_slave_mem.sv
// AXI4 INCR-burst slave backed by a word-addressed RAM with byte strobes.
// Independent write (IDLE/DATA/RESP) and read (IDLE/DATA) engines; 32-bit data only.
module axi4_slave_mem #(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int MEM_DEPTH          = 1024
) (
  input  logic               clk,
  input  logic               rst,
  axi4_slave_mem_if.slave    s_axi,
  output logic               err_wlast
);

  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  logic [C_S_AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

  w_state_t   w_state, w_state_nxt;
  logic [IDX_W-1:0] w_idx;
  logic [7:0] w_cnt, w_len;

  r_state_t   r_state, r_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [7:0] r_cnt, r_len;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic w_last_beat, r_last_beat;
  logic [IDX_W-1:0] aw_idx, ar_idx;

  assign aw_hs = s_axi.s_axi_awvalid && s_axi.s_axi_awready;
  assign w_hs  = s_axi.s_axi_wvalid  && s_axi.s_axi_wready;
  assign b_hs  = s_axi.s_axi_bvalid  && s_axi.s_axi_bready;
  assign ar_hs = s_axi.s_axi_arvalid && s_axi.s_axi_arready;
  assign r_hs  = s_axi.s_axi_rvalid  && s_axi.s_axi_rready;

  assign aw_idx = s_axi.s_axi_awaddr[2 +: IDX_W];
  assign ar_idx = s_axi.s_axi_araddr[2 +: IDX_W];

  // Burst length comes from awlen alone; wlast is only audited.
  assign w_last_beat = (w_cnt == w_len);
  assign r_last_beat = (r_cnt == r_len);

  // Byte-offset and out-of-range address bits carry no meaning here.
  logic unused_addr;
  assign unused_addr = ^{s_axi.s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:IDX_W+2],
                         s_axi.s_axi_awaddr[1:0],
                         s_axi.s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:IDX_W+2],
                         s_axi.s_axi_araddr[1:0]};

  // ---------------- write engine ----------------
  // NOTE: state and data registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path
  // through the case leaves it unassigned and infers a latch.
  always_comb begin
    w_state_nxt = w_state;
    unique case (w_state)
      W_IDLE: if (aw_hs)               w_state_nxt = W_DATA;
      W_DATA: if (w_hs && w_last_beat) w_state_nxt = W_RESP;
      W_RESP: if (b_hs)                w_state_nxt = W_IDLE;
      default:                         w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    s_axi.s_axi_awready = 1'b0;
    s_axi.s_axi_wready  = 1'b0;
    s_axi.s_axi_bvalid  = 1'b0;
    unique case (w_state)
      W_IDLE:  s_axi.s_axi_awready = 1'b1;
      W_DATA:  s_axi.s_axi_wready  = 1'b1;
      W_RESP:  s_axi.s_axi_bvalid  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_idx     <= '0;
      w_cnt     <= '0;
      w_len     <= '0;
      err_wlast <= 1'b0;
    end else begin
      if (aw_hs) begin
        w_idx <= aw_idx;
        w_len <= s_axi.s_axi_awlen;
        w_cnt <= '0;
      end else if (w_hs) begin
        w_idx <= w_idx + 1'b1;
        w_cnt <= w_cnt + 1'b1;
        if (s_axi.s_axi_wlast != w_last_beat) err_wlast <= 1'b1;
      end
    end
  end

  // NOTE: the RAM array is deliberately not reset: contents survive rst, and
  // a resettable array would not map onto a block RAM.
  always_ff @(posedge clk) begin
    if (w_hs) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (s_axi.s_axi_wstrb[i]) mem[w_idx][8*i +: 8] <= s_axi.s_axi_wdata[8*i +: 8];
      end
    end
  end

  // ---------------- read engine ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    unique case (r_state)
      R_IDLE:  if (ar_hs)               r_state_nxt = R_DATA;
      R_DATA:  if (r_hs && r_last_beat) r_state_nxt = R_IDLE;
      default:                          r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi.s_axi_arready = 1'b0;
    s_axi.s_axi_rvalid  = 1'b0;
    unique case (r_state)
      R_IDLE:  s_axi.s_axi_arready = 1'b1;
      R_DATA:  s_axi.s_axi_rvalid  = 1'b1;
      default: ;
    endcase
  end

  assign s_axi.s_axi_rlast = s_axi.s_axi_rvalid && r_last_beat;
  assign s_axi.s_axi_rdata = rdata_q;

  // Reading mem with a non-blocking load returns the pre-write word when a
  // write beat hits the same index on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      rdata_q <= '0;
    end else begin
      if (ar_hs) begin
        rdata_q <= mem[ar_idx];
        r_idx   <= ar_idx + 1'b1;
        r_len   <= s_axi.s_axi_arlen;
        r_cnt   <= '0;
      end else if (r_hs && !r_last_beat) begin
        rdata_q <= mem[r_idx];
        r_idx   <= r_idx + 1'b1;
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Directed bench for axi4_slave_mem; expected read beats go into a scoreboard
// queue that a negedge monitor drains on every R handshake.
module tb_axi4_slave_mem;

  localparam int MEM_DEPTH = 1024;

  logic clk = 1'b0;
  logic rst;
  logic err_wlast;

  always #5 clk = ~clk;

  axi4_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi4_slave_mem #(
    .C_S_AXI_ADDR_WIDTH(32),
    .C_S_AXI_DATA_WIDTH(32),
    .MEM_DEPTH(MEM_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_axi(bus.slave),
    .err_wlast(err_wlast)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
  } rbeat_t;

  rbeat_t exp_r[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: one pop per completed R handshake.
  always @(negedge clk) begin
    rbeat_t e;
    if (!rst && bus.s_axi_rvalid && bus.s_axi_rready) begin
      if (exp_r.size() == 0) begin
        check("r_unexpected_beat", {31'd0, bus.s_axi_rvalid}, 32'd0);
      end else begin
        e = exp_r.pop_front();
        check("rdata", bus.s_axi_rdata, e.data);
        check("rlast", {31'd0, bus.s_axi_rlast}, {31'd0, e.last});
      end
    end
  end

  // All channel tasks enter and leave just after a rising edge.
  task automatic do_aw(input logic [31:0] addr, input logic [7:0] len);
    int n = 0;
    bus.s_axi_awaddr  = addr;
    bus.s_axi_awlen   = len;
    bus.s_axi_awvalid = 1'b1;
    @(negedge clk);
    while (!bus.s_axi_awready && n < 50) begin @(negedge clk); n++; end
    check("awready", {31'd0, bus.s_axi_awready}, 32'd1);
    @(posedge clk); #1;
    bus.s_axi_awvalid = 1'b0;
  endtask

  task automatic do_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    bus.s_axi_wdata  = data;
    bus.s_axi_wstrb  = strb;
    bus.s_axi_wlast  = last;
    bus.s_axi_wvalid = 1'b1;
    @(negedge clk);
    while (!bus.s_axi_wready && n < 50) begin @(negedge clk); n++; end
    check("wready", {31'd0, bus.s_axi_wready}, 32'd1);
    @(posedge clk); #1;
    bus.s_axi_wvalid = 1'b0;
    bus.s_axi_wlast  = 1'b0;
  endtask

  task automatic do_b();
    int n = 0;
    bus.s_axi_bready = 1'b1;
    @(negedge clk);
    while (!bus.s_axi_bvalid && n < 50) begin @(negedge clk); n++; end
    check("bvalid", {31'd0, bus.s_axi_bvalid}, 32'd1);
    @(posedge clk); #1;
    bus.s_axi_bready = 1'b0;
  endtask

  task automatic do_ar(input logic [31:0] addr, input logic [7:0] len);
    int n = 0;
    bus.s_axi_araddr  = addr;
    bus.s_axi_arlen   = len;
    bus.s_axi_arvalid = 1'b1;
    @(negedge clk);
    while (!bus.s_axi_arready && n < 50) begin @(negedge clk); n++; end
    check("arready", {31'd0, bus.s_axi_arready}, 32'd1);
    @(posedge clk); #1;
    bus.s_axi_arvalid = 1'b0;
  endtask

  task automatic write_word(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    do_aw(addr, 8'd0);
    do_w(data, strb, 1'b1);
    do_b();
  endtask

  task automatic push_r(input logic [31:0] data, input logic last);
    rbeat_t e;
    e.data = data;
    e.last = last;
    exp_r.push_back(e);
  endtask

  // Returns the number of cycles the scoreboard took to empty.
  task automatic drain(input string name, output int cycles);
    cycles = 0;
    while (exp_r.size() != 0 && cycles < 100) begin @(posedge clk); #1; cycles++; end
    check(name, exp_r.size(), 32'd0);
  endtask

  initial begin
    int cyc;
    logic [5:0] pat;

    rst = 1'b1;
    bus.s_axi_awvalid = 1'b0; bus.s_axi_awaddr = '0; bus.s_axi_awlen = '0;
    bus.s_axi_wvalid  = 1'b0; bus.s_axi_wdata  = '0; bus.s_axi_wstrb = '0; bus.s_axi_wlast = 1'b0;
    bus.s_axi_bready  = 1'b0;
    bus.s_axi_arvalid = 1'b0; bus.s_axi_araddr = '0; bus.s_axi_arlen = '0;
    bus.s_axi_rready  = 1'b1;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_awready", {31'd0, bus.s_axi_awready}, 32'd1);
    check("rst_arready", {31'd0, bus.s_axi_arready}, 32'd1);
    check("rst_wready",  {31'd0, bus.s_axi_wready},  32'd0);
    check("rst_bvalid",  {31'd0, bus.s_axi_bvalid},  32'd0);
    check("rst_rvalid",  {31'd0, bus.s_axi_rvalid},  32'd0);
    check("rst_rlast",   {31'd0, bus.s_axi_rlast},   32'd0);
    check("rst_rdata",   bus.s_axi_rdata,            32'd0);
    check("rst_err",     {31'd0, err_wlast},         32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // 4-beat write to words 4..7.
    do_aw(32'h10, 8'd3);
    do_w(32'hA0, 4'hF, 1'b0);
    do_w(32'hA1, 4'hF, 1'b0);
    do_w(32'hA2, 4'hF, 1'b0);
    check("s1_bvalid_before_last", {31'd0, bus.s_axi_bvalid}, 32'd0);
    do_w(32'hA3, 4'hF, 1'b1);
    check("s1_bvalid_after_last", {31'd0, bus.s_axi_bvalid}, 32'd1);
    do_b();
    check("s1_awready_after_b", {31'd0, bus.s_axi_awready}, 32'd1);
    check("s1_err_wlast", {31'd0, err_wlast}, 32'd0);

    // 4-beat read back with continuous rready.
    push_r(32'hA0, 1'b0); push_r(32'hA1, 1'b0); push_r(32'hA2, 1'b0); push_r(32'hA3, 1'b1);
    do_ar(32'h10, 8'd3);
    check("s2_rvalid_latency", {31'd0, bus.s_axi_rvalid}, 32'd1);
    drain("s2_drain", cyc);
    check("s2_beats_consecutive", cyc, 32'd4);
    check("s2_rvalid_after_last", {31'd0, bus.s_axi_rvalid}, 32'd0);

    // Byte strobes: 0x11223344 overwritten with 0xFFFFFFFF under strb 0x5.
    write_word(32'h10, 32'h11223344, 4'hF);
    write_word(32'h10, 32'hFFFFFFFF, 4'h5);
    push_r(32'h11FF33FF, 1'b1);
    do_ar(32'h10, 8'd0);
    check("s3_rlast_first_beat", {31'd0, bus.s_axi_rlast}, 32'd1);
    drain("s3_drain", cyc);

    // Index wrap at the top of memory.
    do_aw((MEM_DEPTH - 1) * 4, 8'd1);
    do_w(32'hB0, 4'hF, 1'b0);
    do_w(32'hB1, 4'hF, 1'b1);
    do_b();
    push_r(32'hB0, 1'b0); push_r(32'hB1, 1'b1);
    do_ar((MEM_DEPTH - 1) * 4, 8'd1);
    drain("s4_wrap_drain", cyc);
    push_r(32'hB1, 1'b1);
    do_ar(32'h0, 8'd0);
    drain("s4_word0_drain", cyc);

    // Early wlast: error flagged, burst length still follows awlen.
    do_aw(32'h40, 8'd3);
    do_w(32'hC0, 4'hF, 1'b0);
    do_w(32'hC1, 4'hF, 1'b1);
    check("s5_err_wlast_set", {31'd0, err_wlast}, 32'd1);
    do_w(32'hC2, 4'hF, 1'b0);
    check("s5_no_early_bvalid", {31'd0, bus.s_axi_bvalid}, 32'd0);
    do_w(32'hC3, 4'hF, 1'b0);
    check("s5_bvalid_after_beat3", {31'd0, bus.s_axi_bvalid}, 32'd1);
    do_b();
    check("s5_err_wlast_sticky", {31'd0, err_wlast}, 32'd1);
    push_r(32'hC0, 1'b0); push_r(32'hC1, 1'b0); push_r(32'hC2, 1'b0); push_r(32'hC3, 1'b1);
    do_ar(32'h40, 8'd3);
    drain("s5_readback_drain", cyc);

    // rready 1,0,0,1,1,1: stalled beat must hold rdata/rlast.
    push_r(32'h11FF33FF, 1'b0); push_r(32'hA1, 1'b0); push_r(32'hA2, 1'b0); push_r(32'hA3, 1'b1);
    pat = 6'b111001;
    do_ar(32'h10, 8'd3);
    for (int k = 0; k < 6; k++) begin
      bus.s_axi_rready = pat[k];
      @(negedge clk);
      if (!pat[k]) begin
        check("s6_stall_rvalid", {31'd0, bus.s_axi_rvalid}, 32'd1);
        if (exp_r.size() != 0) begin
          check("s6_stall_rdata", bus.s_axi_rdata, exp_r[0].data);
          check("s6_stall_rlast", {31'd0, bus.s_axi_rlast}, {31'd0, exp_r[0].last});
        end else begin
          check("s6_stall_queue", exp_r.size(), 32'd1);
        end
      end
      @(posedge clk); #1;
    end
    bus.s_axi_rready = 1'b1;
    drain("s6_drain", cyc);

    // Asynchronous reset in the middle of a stalled read.
    bus.s_axi_rready = 1'b0;
    do_ar(32'h10, 8'd3);
    check("s7_rvalid_before_rst", {31'd0, bus.s_axi_rvalid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("s7_rvalid_async", {31'd0, bus.s_axi_rvalid}, 32'd0);
    check("s7_rlast_async",  {31'd0, bus.s_axi_rlast},  32'd0);
    check("s7_rdata_async",  bus.s_axi_rdata,           32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("s7_arready_after", {31'd0, bus.s_axi_arready}, 32'd1);
    check("s7_awready_after", {31'd0, bus.s_axi_awready}, 32'd1);
    check("s7_err_cleared",   {31'd0, err_wlast},         32'd0);
    bus.s_axi_rready = 1'b1;
    push_r(32'h11FF33FF, 1'b0); push_r(32'hA1, 1'b0); push_r(32'hA2, 1'b0); push_r(32'hA3, 1'b1);
    do_ar(32'h10, 8'd3);
    drain("s7_mem_kept_drain", cyc);
    push_r(32'hB0, 1'b0); push_r(32'hB1, 1'b1);
    do_ar((MEM_DEPTH - 1) * 4, 8'd1);
    drain("s7_wrap_kept_drain", cyc);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
